// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the ADC chip-select initiator.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } adc_state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int LEAD_BITS  = 4;
  localparam int BIT_CNT_W  = 5;
  localparam int GAP_CNT_W  = 8;

endpackage

// File: rtl/adc_cs_generator_sclk_divisor.sv
// Half-period tick generator: pulses `tick` every CLK_DIV enabled cycles,
// restarting the period whenever `load` is asserted.
module sclk_divisor #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_cs_generator.sv
// ADC chip-select initiator: frames one 16-bit serial read per start request.
// Optional leading-zero check on the frame header: ADC_LEADZERO_CHECK_EN.
module adc_cs_generator
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              start,
  input  logic              SDATA,
  output logic              CS,
  output logic              SCLK,
  output logic [DATA_W-1:0] dato,
  output logic              listo,
  output logic              busy,
  output logic              error
);

  // Leading header bits are only retained when they are checked.
`ifdef ADC_LEADZERO_CHECK_EN
  localparam int SHIFT_W = FRAME_BITS;
`else
  localparam int SHIFT_W = DATA_W;
`endif

  adc_state_e            state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  busy_q, busy_d;
  logic                  listo_q, listo_d;
  logic [DATA_W-1:0]     dato_q, dato_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic                  tick, div_load, div_en, frame_done, gap_done;

  assign div_load   = (state_q == IDLE);
  assign div_en     = (state_q == SETUP) || (state_q == SHIFT);
  assign frame_done = (state_q == SHIFT) && tick && sclk_q &&
                      (bit_cnt_q == BIT_CNT_W'(FRAME_BITS));
  assign gap_done   = (state_q == GAP) && (gap_cnt_q == '0);

  sclk_divisor #(.CLK_DIV(CLK_DIV)) u_sclk_divisor (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (EN && start) state_d = SETUP;
      SETUP:   if (tick)        state_d = SHIFT;
      SHIFT:   if (frame_done)  state_d = GAP;
      GAP:     if (gap_done)    state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    listo_d   = 1'b0;
    dato_d    = dato_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        cs_d      = 1'b1;
        sclk_d    = 1'b1;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        if (EN && start) begin
          cs_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      SETUP: begin
        if (tick) sclk_d = 1'b0;
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            shift_d   = {shift_q[SHIFT_W-2:0], SDATA};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (frame_done) begin
            cs_d      = 1'b1;
            dato_d    = shift_q[DATA_W-1:0];
            listo_d   = 1'b1;
            gap_cnt_d = GAP_CNT_W'(GAP_CYC - 1);
          end else begin
            sclk_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (gap_done) busy_d = 1'b0;
        else          gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      listo_q   <= 1'b0;
      dato_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      listo_q   <= listo_d;
      dato_q    <= dato_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef ADC_LEADZERO_CHECK_EN
  logic error_q, error_d;

  assign error_d = frame_done && (shift_q[FRAME_BITS-1 -: LEAD_BITS] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) error_q <= 1'b0;
    else      error_q <= error_d;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign CS    = cs_q;
  assign SCLK  = sclk_q;
  assign busy  = busy_q;
  assign listo = listo_q;
  assign dato  = dato_q;

endmodule
